// File: rtl/mnist_sample_packer_if.sv
// mnist_sample_packer_if: byte-stream input and packed-sample output bundle of the MNIST packer.
//   flush        discard the partially assembled sample (synchronous)
//   s_valid      input byte valid
//   s_data       label or pixel byte
//   s_ready      packer accepts a byte this cycle
//   image_data   [793:10] binarized pixels, [9:0] one-hot label
//   sample_valid image_data holds a live sample
//   sample_done  pulse on the last hold cycle of a sample
//   label_err    pulse after an accepted label byte above 9
//   sample_cnt   samples whose hold completed, wrapping
interface mnist_sample_packer_if #(parameter int CNT_W = 16);
  logic             flush;
  logic             s_valid;
  logic [7:0]       s_data;
  logic             s_ready;
  logic [793:0]     image_data;
  logic             sample_valid;
  logic             sample_done;
  logic             label_err;
  logic [CNT_W-1:0] sample_cnt;
  modport master (output flush, s_valid, s_data,
                  input s_ready, image_data, sample_valid, sample_done, label_err, sample_cnt);
  modport slave  (input flush, s_valid, s_data,
                  output s_ready, image_data, sample_valid, sample_done, label_err, sample_cnt);
endinterface

// File: rtl/mnist_sample_packer.sv
// mnist_sample_packer: packs a label byte plus 784 pixel bytes into a 794-bit training word and holds it.
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    mnist_sample_packer_if.slave (byte stream in, packed sample out)
module mnist_sample_packer #(
  parameter int PIX_THRESH  = 128,
  parameter int HOLD_CYCLES = 1,
  parameter int CNT_W       = 16
) (
  input logic                   clk,
  input logic                   rst_n,
  mnist_sample_packer_if.slave  bus
);
  typedef enum logic [1:0] {S_LABEL, S_PIX, S_WAIT} state_t;
  localparam logic [15:0] HOLD_INIT = 16'(HOLD_CYCLES - 1);
  state_t           state_q, state_d;
  logic [9:0]       pix_cnt_q, pix_cnt_d;
  logic [783:0]     work_pix_q;
  logic [9:0]       work_label_q;
  logic [793:0]     image_q;
  logic             valid_q, valid_d;
  logic [15:0]      hold_q, hold_d;
  logic [CNT_W-1:0] cnt_q;
  logic             label_err_q;
  logic             xfer, done, load, pix_bit;
  logic [9:0]       onehot;
  assign bus.s_ready      = (state_q != S_WAIT) && !bus.flush;
  assign xfer             = bus.s_valid && bus.s_ready;
  assign done             = valid_q && hold_q == 16'd0;
  // the output slot frees up either when empty or on the final hold cycle of the current sample
  assign load             = state_q == S_WAIT && !bus.flush && (!valid_q || done);
  assign pix_bit          = int'(bus.s_data) >= PIX_THRESH;
  assign onehot           = bus.s_data <= 8'd9 ? 10'd1 << bus.s_data[3:0] : 10'd0;
  assign bus.image_data   = image_q;
  assign bus.sample_valid = valid_q;
  assign bus.sample_done  = done;
  assign bus.label_err    = label_err_q;
  assign bus.sample_cnt   = cnt_q;
  always_comb begin
    state_d   = state_q;
    pix_cnt_d = pix_cnt_q;
    case (state_q)
      S_LABEL: begin
        pix_cnt_d = '0;
        if (xfer) state_d = S_PIX;
      end
      S_PIX: begin
        if (bus.flush) begin
          state_d   = S_LABEL;
          pix_cnt_d = '0;
        end else if (xfer) begin
          pix_cnt_d = pix_cnt_q + 10'd1;
          if (pix_cnt_q == 10'd783) state_d = S_WAIT;
        end
      end
      S_WAIT: if (bus.flush || load) state_d = S_LABEL;
      default: state_d = S_LABEL;
    endcase
  end
  always_comb begin
    valid_d = load || (valid_q && !done);
    hold_d  = load ? HOLD_INIT : (valid_q && hold_q != 16'd0) ? hold_q - 16'd1 : hold_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_LABEL;
      pix_cnt_q    <= '0;
      work_pix_q   <= '0;
      work_label_q <= '0;
      image_q      <= '0;
      valid_q      <= 1'b0;
      hold_q       <= '0;
      cnt_q        <= '0;
      label_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pix_cnt_q   <= pix_cnt_d;
      valid_q     <= valid_d;
      hold_q      <= hold_d;
      cnt_q       <= cnt_q + CNT_W'(done);
      label_err_q <= xfer && state_q == S_LABEL && bus.s_data > 8'd9;
      if (xfer && state_q == S_LABEL) work_label_q <= onehot;
      if (xfer && state_q == S_PIX) work_pix_q[pix_cnt_q] <= pix_bit;
      if (load) image_q <= {work_pix_q, work_label_q};
    end
  end
endmodule

// File: tb/tb_mnist_sample_packer.sv
// tb_mnist_sample_packer: scoreboard bench for three packers with hold lengths 1, 4 and 800.
module tb_mnist_sample_packer;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic         rn [3];
  logic         sv [3];
  logic [7:0]   sd [3];
  logic         fl [3];
  logic         rdy [3];
  logic         mv [3];
  logic         md [3];
  logic         ml [3];
  logic [793:0] mi [3];
  logic [15:0]  mc [3];
  mnist_sample_packer_if #(.CNT_W(16)) i0 ();
  mnist_sample_packer_if #(.CNT_W(16)) i1 ();
  mnist_sample_packer_if #(.CNT_W(16)) i2 ();
  assign i0.flush = fl[0]; assign i0.s_valid = sv[0]; assign i0.s_data = sd[0];
  assign i1.flush = fl[1]; assign i1.s_valid = sv[1]; assign i1.s_data = sd[1];
  assign i2.flush = fl[2]; assign i2.s_valid = sv[2]; assign i2.s_data = sd[2];
  assign rdy[0] = i0.s_ready; assign mv[0] = i0.sample_valid; assign md[0] = i0.sample_done;
  assign rdy[1] = i1.s_ready; assign mv[1] = i1.sample_valid; assign md[1] = i1.sample_done;
  assign rdy[2] = i2.s_ready; assign mv[2] = i2.sample_valid; assign md[2] = i2.sample_done;
  assign ml[0] = i0.label_err; assign mi[0] = i0.image_data; assign mc[0] = i0.sample_cnt;
  assign ml[1] = i1.label_err; assign mi[1] = i1.image_data; assign mc[1] = i1.sample_cnt;
  assign ml[2] = i2.label_err; assign mi[2] = i2.image_data; assign mc[2] = i2.sample_cnt;
  mnist_sample_packer #(.PIX_THRESH(128), .HOLD_CYCLES(1),   .CNT_W(16)) u0 (.clk(clk), .rst_n(rn[0]), .bus(i0.slave));
  mnist_sample_packer #(.PIX_THRESH(128), .HOLD_CYCLES(4),   .CNT_W(16)) u1 (.clk(clk), .rst_n(rn[1]), .bus(i1.slave));
  mnist_sample_packer #(.PIX_THRESH(128), .HOLD_CYCLES(800), .CNT_W(16)) u2 (.clk(clk), .rst_n(rn[2]), .bus(i2.slave));
  int checks = 0;
  int errors = 0;
  int ndone [3];
  int run [3];
  int lerr [3];
  logic [793:0] q0 [$];
  logic [793:0] q1 [$];
  logic [793:0] q2 [$];
  function automatic int hold_of(input int d);
    return d == 0 ? 1 : d == 1 ? 4 : 800;
  endfunction
  function automatic logic [7:0] pix_byte(input int mode, input int k);
    case (mode)
      0: return k % 2 == 1 ? 8'hFF : 8'h00;
      1: return k == 0 ? 8'd127 : k == 783 ? 8'd128 : 8'(k);
      2: return k % 3 == 0 ? 8'hC8 : 8'h10;
      default: return 8'hFF;
    endcase
  endfunction
  function automatic logic [783:0] exp_pix(input int mode);
    logic [783:0] e;
    e = {392{2'b10}};
    if (mode == 1) begin
      for (int k = 0; k < 784; k++) e[k] = k[7];
      e[0] = 1'b0;
      e[783] = 1'b1;
    end else if (mode == 2) begin
      for (int k = 0; k < 784; k++) e[k] = k % 3 == 0;
    end
    return e;
  endfunction
  task automatic chk(input string name, input logic [793:0] act, input logic [793:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  task automatic push(input int d, input logic [793:0] v);
    if (d == 0) q0.push_back(v);
    else if (d == 1) q1.push_back(v);
    else q2.push_back(v);
  endtask
  function automatic int qsize(input int d);
    return d == 0 ? q0.size() : d == 1 ? q1.size() : q2.size();
  endfunction
  function automatic logic [793:0] qpop(input int d);
    if (d == 0) return q0.pop_front();
    if (d == 1) return q1.pop_front();
    return q2.pop_front();
  endfunction
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (!rn[d]) begin
        run[d] = 0;
        ndone[d] = 0;
        lerr[d] = 0;
      end else begin
        if (ml[d]) lerr[d]++;
        run[d] = mv[d] ? run[d] + 1 : 0;
        if (md[d]) begin
          chk("hold_len", 794'(run[d]), 794'(hold_of(d)));
          run[d] = 0;
          chk("sample_cnt_at_done", 794'(mc[d]), 794'(ndone[d] % 65536));
          ndone[d]++;
          if (qsize(d) == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_sample dut=%0d actual=%0h required=none", d, mi[d]);
          end else chk("image_data", mi[d], qpop(d));
        end
      end
    end
  end
  task automatic send_byte(input int d, input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    sv[d] = 1'b1;
    sd[d] = b;
    #1;
    while (!rdy[d] && n < 2000) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!rdy[d]) begin
      checks++;
      errors++;
      $display("FAIL handshake_timeout dut=%0d actual=s_ready0 required=s_ready1", d);
    end
    @(posedge clk);
    #1 sv[d] = 1'b0;
  endtask
  task automatic send_sample(input int d, input logic [7:0] label, input int mode, input logic [9:0] exp_label);
    push(d, {exp_pix(mode), exp_label});
    send_byte(d, label);
    for (int k = 0; k < 784; k++) send_byte(d, pix_byte(mode, k));
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
  initial begin
    int bad, n;
    for (int d = 0; d < 3; d++) begin
      rn[d] = 1'b0; sv[d] = 1'b0; sd[d] = 8'h00; fl[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk("rst_image", mi[0], '0);
    chk("rst_valid", 794'(mv[0]), 794'(0));
    chk("rst_done", 794'(md[0]), 794'(0));
    chk("rst_label_err", 794'(ml[0]), 794'(0));
    chk("rst_cnt", 794'(mc[0]), 794'(0));
    for (int d = 0; d < 3; d++) rn[d] = 1'b1;
    @(negedge clk);
    #1 chk("ready_after_rst", 794'(rdy[0]), 794'(1));
    // alternating pixels, label 3, latency of two cycles after the last byte
    send_sample(0, 8'd3, 0, 10'b0000001000);
    @(negedge clk);
    chk("latency_wait", 794'(mv[0]), 794'(0));
    @(negedge clk);
    chk("latency_valid", 794'(mv[0]), 794'(1));
    @(negedge clk);
    chk("valid_drops", 794'(mv[0]), 794'(0));
    chk("cnt_one", 794'(mc[0]), 794'(1));
    // threshold boundary 127 / 128 at the first and last pixel
    send_sample(0, 8'd5, 1, 10'b0000100000);
    repeat (3) @(negedge clk);
    chk("bit10_127", 794'(mi[0][10]), 794'(0));
    chk("bit793_128", 794'(mi[0][793]), 794'(1));
    // out-of-range label still delivers with a zero label field
    send_sample(0, 8'h0C, 0, 10'b0);
    repeat (3) @(negedge clk);
    chk("label_err_once", 794'(lerr[0]), 794'(1));
    chk("label_zero", 794'(mi[0][9:0]), 794'(0));
    chk("cnt_three", 794'(mc[0]), 794'(3));
    // flush after 400 pixels, then label 7
    send_byte(0, 8'd5);
    for (int k = 0; k < 400; k++) send_byte(0, 8'hFF);
    @(negedge clk);
    fl[0] = 1'b1; sv[0] = 1'b1; sd[0] = 8'hFF;
    #1 chk("flush_ready_low", 794'(rdy[0]), 794'(0));
    @(posedge clk);
    #1 begin fl[0] = 1'b0; sv[0] = 1'b0; end
    send_sample(0, 8'd7, 2, 10'b0010000000);
    repeat (3) @(negedge clk);
    chk("cnt_after_flush", 794'(mc[0]), 794'(4));
    chk("label_err_flush", 794'(lerr[0]), 794'(1));
    // hold of 4 cycles
    send_sample(1, 8'd1, 0, 10'b0000000010);
    repeat (7) @(negedge clk);
    chk("b_cnt_one", 794'(mc[1]), 794'(1));
    send_sample(1, 8'd2, 1, 10'b0000000100);
    repeat (7) @(negedge clk);
    chk("b_cnt_two", 794'(mc[1]), 794'(2));
    // reset pulse in the middle of a hold
    send_sample(1, 8'd9, 2, 10'b1000000000);
    @(negedge clk);
    @(negedge clk);
    chk("b_valid_before_rst", 794'(mv[1]), 794'(1));
    #2 rn[1] = 1'b0;
    #1;
    chk("b_rst_image", mi[1], '0);
    chk("b_rst_valid", 794'(mv[1]), 794'(0));
    chk("b_rst_done", 794'(md[1]), 794'(0));
    chk("b_rst_cnt", 794'(mc[1]), 794'(0));
    q1.delete();
    @(negedge clk);
    #2 rn[1] = 1'b1;
    @(negedge clk);
    #1 chk("b_ready_after_rst", 794'(rdy[1]), 794'(1));
    repeat (8) @(negedge clk);
    chk("b_cnt_zero", 794'(mc[1]), 794'(0));
    chk("b_valid_idle", 794'(mv[1]), 794'(0));
    // long hold: second sample waits in S_WAIT and then replaces the first back-to-back
    send_sample(2, 8'd4, 0, 10'b0000010000);
    send_sample(2, 8'd6, 1, 10'b0001000000);
    bad = 0;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      if (!md[2] && rdy[2]) bad++;
      n++;
    end while (!md[2] && n < 2000);
    chk("c_ready_low_in_wait", 794'(bad), 794'(0));
    chk("c_done_seen", 794'(md[2]), 794'(1));
    @(negedge clk);
    chk("c_back_to_back", 794'(mv[2]), 794'(1));
    chk("c_cnt_one", 794'(mc[2]), 794'(1));
    repeat (805) @(negedge clk);
    chk("c_cnt_two", 794'(mc[2]), 794'(2));
    chk("queues_empty", 794'(q0.size() + q1.size() + q2.size()), 794'(0));
    chk("c_no_label_err", 794'(lerr[2]), 794'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
